ram8_master: RTL and testbench

Sequencing initiator for an 8-word × 16-bit RAM with a single clocked write port and a combinational read path (`load`, `address[2:0]`, `in[15:0]` → `out[15:0]`). On a one-cycle `start` command it runs one of two operations. FILL writes an arithmetic sequence into all eight words. SUM reads all eight words and returns their 16-bit wrapping sum. It sits between a controller or test harness and the memory, driving the memory's write-side pins and consuming its read data.

---
 rtl/ram8_master.sv | 120 ++++++++++++
 tb/tb_ram8_master.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ram8_master.sv
// Sequencing initiator for an 8 x 16 RAM: FILL writes base + i*step into every word,
// SUM reads all eight words back and reports their wrapping 16-bit sum.
module ram8_master (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [15:0] base,
    input  logic [15:0] step,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        mem_load,
    output logic [2:0]  mem_address,
    output logic [15:0] mem_in,
    input  logic [15:0] mem_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_SUM  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] value_q, value_d;
    logic [15:0] step_q, step_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] result_q, result_d;
    logic [2:0]  addr_q, addr_d;
    logic [15:0] din_q, din_d;
    logic [15:0] acc_sum;

    assign acc_sum = acc_q + mem_out;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        value_d     = value_q;
        step_d      = step_q;
        acc_d       = acc_q;
        result_d    = result_q;
        addr_d      = addr_q;
        din_d       = din_q;
        mem_load    = 1'b0;
        mem_address = addr_q;
        mem_in      = din_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    value_d = base;
                    step_d  = step;
                    acc_d   = 16'h0000;
                    idx_d   = 3'd0;
                    state_d = op ? S_SUM : S_FILL;
                end
            end
            S_FILL: begin
                mem_load    = 1'b1;
                mem_address = idx_q;
                mem_in      = value_q;
                addr_d      = idx_q;
                din_d       = value_q;
                value_d     = value_q + step_q;
                idx_d       = idx_q + 3'd1;
                // the value written in the idx 7 cycle is base + 7*step
                if (idx_q == 3'd7) begin
                    result_d = value_q;
                    state_d  = S_DONE;
                end
            end
            S_SUM: begin
                mem_address = idx_q;
                addr_d      = idx_q;
                acc_d       = acc_sum;
                idx_d       = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    result_d = acc_sum;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= 3'd0;
            value_q  <= 16'h0000;
            step_q   <= 16'h0000;
            acc_q    <= 16'h0000;
            result_q <= 16'h0000;
            addr_q   <= 3'd0;
            din_q    <= 16'h0000;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            value_q  <= value_d;
            step_q   <= step_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_ram8_master.sv
// Scoreboard bench for ram8_master: a behavioural RAM sits behind the DUT, commands push
// expected traces into a queue and a negedge monitor checks every cycle against the front entry.
module tb_ram8_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [15:0] base = 16'h0000;
    logic [15:0] step = 16'h0000;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        mem_load;
    logic [2:0]  mem_address;
    logic [15:0] mem_in;
    logic [15:0] mem_out;

    logic [15:0] ram [8];
    logic [15:0] ref_ram [8];

    typedef struct {
        int          s;
        bit          op;
        logic [15:0] base;
        logic [15:0] step;
        logic [15:0] res;
        int          abort_k;
    } exp_t;

    exp_t sb[$];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [15:0] last_res = 16'h0000;
    logic [2:0]  last_addr = 3'd0;
    logic [15:0] last_din = 16'h0000;

    always #5 clk = ~clk;

    ram8_master dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .base       (base),
        .step       (step),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .mem_load   (mem_load),
        .mem_address(mem_address),
        .mem_in     (mem_in),
        .mem_out    (mem_out)
    );

    always @(posedge clk) begin
        if (mem_load) ram[mem_address] <= mem_in;
    end
    assign mem_out = ram[mem_address];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, exp);
        end
    endtask

    // Reference: FILL writes base + i*step to words 0..7 (only 0..k-1 when aborted in cycle k);
    // SUM returns the wrapping sum of the current contents.
    task automatic model(input bit o, input logic [15:0] b, input logic [15:0] st,
                         input int s, input int k, output exp_t e);
        logic [15:0] sum;
        e.s = s; e.op = o; e.base = b; e.step = st; e.abort_k = k;
        if (!o) begin
            for (int i = 0; i < 8; i++)
                if (k == 0 || i < k) ref_ram[i] = b + 16'(i) * st;
            e.res = b + 16'd7 * st;
        end else begin
            sum = 16'h0000;
            for (int i = 0; i < 8; i++) sum = sum + ref_ram[i];
            e.res = sum;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic        e_busy, e_done, e_load;
            logic [2:0]  e_addr;
            logic [15:0] e_din, e_res;
            int          rel;
            while (sb.size() > 0 && sb[0].abort_k > 0 && (cyc - sb[0].s) > sb[0].abort_k) begin
                last_res = 16'h0000; last_addr = 3'd0; last_din = 16'h0000;
                $display("txn aborted s=%0d", sb[0].s);
                void'(sb.pop_front());
            end
            e_busy = 1'b0; e_done = 1'b0; e_load = 1'b0;
            e_addr = last_addr; e_din = last_din; e_res = last_res;
            rel = -1;
            if (sb.size() > 0) begin
                rel = cyc - sb[0].s;
                if (rel >= 1 && rel <= 8) begin
                    e_busy = 1'b1;
                    e_addr = 3'(rel - 1);
                    if (!sb[0].op) begin
                        e_load = 1'b1;
                        e_din  = sb[0].base + 16'(rel - 1) * sb[0].step;
                    end
                end else if (rel == 9) begin
                    e_busy = 1'b1; e_done = 1'b1; e_res = sb[0].res;
                end
            end
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("mem_load", 32'(mem_load), 32'(e_load));
            chk("mem_address", 32'(mem_address), 32'(e_addr));
            chk("mem_in", 32'(mem_in), 32'(e_din));
            chk("result", 32'(result), 32'(e_res));
            last_addr = e_addr; last_din = e_din;
            if (rel == 9) begin
                last_res = e_res;
                $display("txn %s s=%0d base=%h step=%h result=%h expected=%h",
                         sb[0].op ? "SUM " : "FILL", sb[0].s, sb[0].base, sb[0].step, result, e_res);
                void'(sb.pop_front());
            end
        end
    end

    task automatic next_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        op = 1'($urandom); base = 16'($urandom); step = 16'($urandom);
    endtask

    // issue in the current cycle (cycle 0); returns at the start of cycle 1
    task automatic issue(input bit o, input logic [15:0] b, input logic [15:0] st, input int k);
        exp_t e;
        start = 1'b1; op = o; base = b; step = st;
        model(o, b, st, cyc, k, e);
        sb.push_back(e);
        next_cycles(1);
        start = 1'b0;
        scramble();
    endtask

    initial begin
        exp_t e;
        next_cycles(3);
        reset = 1'b0;
        chk_en = 1'b1;
        next_cycles(2);

        issue(1'b0, 16'h0010, 16'h0003, 0); next_cycles(9);
        issue(1'b1, 16'h0000, 16'h0000, 0); next_cycles(9);
        issue(1'b0, 16'hFFFF, 16'h0001, 0); next_cycles(9);
        issue(1'b1, 16'h0000, 16'h0000, 0); next_cycles(9);

        // stray starts in cycles 3 and 9 of a running FILL
        issue(1'b0, 16'h0100, 16'h0100, 0);
        next_cycles(2); start = 1'b1; op = 1'b1;
        next_cycles(1); start = 1'b0;
        next_cycles(5); start = 1'b1; op = 1'b1;
        next_cycles(1); start = 1'b0;
        next_cycles(1);

        // preload 0xAAAA, then reset in cycle 4 of a FILL
        issue(1'b0, 16'hAAAA, 16'h0000, 0); next_cycles(9);
        issue(1'b0, 16'h0001, 16'h0001, 4);
        next_cycles(3); reset = 1'b1; start = 1'b1; op = 1'b1;
        next_cycles(1); reset = 1'b0; start = 1'b0;
        next_cycles(2);
        issue(1'b1, 16'h0000, 16'h0000, 0); next_cycles(9);

        // start held high: a new command every 10 cycles
        start = 1'b1;
        for (int n = 0; n < 4; n++) begin
            op = 1'(n); base = 16'($urandom); step = 16'($urandom);
            model(op, base, step, cyc, 0, e);
            sb.push_back(e);
            next_cycles(1);
            base = 16'($urandom); step = 16'($urandom); op = 1'($urandom);
            next_cycles(9);
        end
        start = 1'b0;
        next_cycles(2);

        for (int n = 0; n < 8; n++) begin
            issue(1'($urandom), 16'($urandom), 16'($urandom), 0);
            next_cycles(9 + $urandom_range(0, 3));
        end

        next_cycles(12);
        chk("queue_drained", 32'(sb.size()), 32'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("ram[%0d]", i), 32'(ram[i]), 32'(ref_ram[i]));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
